// File: rtl/fetch_ctrl_if.sv
// Core-to-cache instruction port: registered request (re/sel/addr) from the core,
// single-cycle ack with the returned instruction from the cache.
interface c2c_instr #(
  parameter int XLEN = 32
) ();
  logic            re;
  logic [3:0]      sel;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [31:0]     instr;

  modport master (output re, sel, addr, input ack, instr);
  modport slave  (input re, sel, addr, output ack, instr);
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the fetch PC, issues one cache request at a time, queues returns for decode.
// Latency: ack at edge N -> fq_valid in cycle N+1; with a 1-cycle-ack cache, one instruction per 2 cycles.
// Backpressure: a request issues only when the queue will have a free slot; redirects flush the queue.
module fetch_ctrl #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FQ_DEPTH     = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  c2c_instr.master         imem,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             fq_valid,
  output logic [31:0]      fq_instr,
  output logic [XLEN-1:0]  fq_pc,
  input  logic             fq_ready
);

  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state_q, state_n;
  logic [XLEN-1:0] pc_q, pc_n;
  logic            re_q, re_n;
  logic [3:0]      sel_q, sel_n;
  logic [XLEN-1:0] addr_q, addr_n;

  logic [31:0]     q_instr [FQ_DEPTH];
  logic [XLEN-1:0] q_pc    [FQ_DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q, count_after;

  logic            acked, push, pop, credit;
  logic [XLEN-1:0] target, pc_inc;

  assign imem.re   = re_q;
  assign imem.sel  = sel_q;
  assign imem.addr = addr_q;

  assign fq_valid = (count_q != '0);
  assign fq_instr = q_instr[head_q];
  assign fq_pc    = q_pc[head_q];

  always_comb begin
    acked       = re_q && imem.ack;
    pop         = fq_valid && fq_ready;
    push        = acked && (state_q == FETCH) && !redirect_valid;
    count_after = count_q + CW'(push) - CW'(pop);
    credit      = count_after < CW'(FQ_DEPTH);
    target      = redirect_pc & ~XLEN'(3);
    pc_inc      = pc_q + XLEN'(4);

    state_n = state_q;
    pc_n    = pc_q;
    re_n    = re_q;
    addr_n  = addr_q;

    if (redirect_valid) begin
      pc_n = target;
      // An in-flight request cannot be cancelled on the bus; ride it out in FLUSH.
      if (re_q && !imem.ack) begin
        state_n = FLUSH;
      end else begin
        state_n = FETCH;
        re_n    = 1'b1;
        addr_n  = target;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (!re_q || acked) begin
            if (acked) pc_n = pc_inc;
            if (credit) begin
              re_n   = 1'b1;
              addr_n = acked ? pc_inc : pc_q;
            end else begin
              re_n    = 1'b0;
              state_n = STALL;
            end
          end
        end
        STALL: begin
          if (credit) begin
            re_n    = 1'b1;
            addr_n  = pc_q;
            state_n = FETCH;
          end
        end
        FLUSH: begin
          // Stale return is dropped; pc already holds the redirect target.
          if (acked) begin
            if (credit) begin
              re_n    = 1'b1;
              addr_n  = pc_q;
              state_n = FETCH;
            end else begin
              re_n    = 1'b0;
              state_n = STALL;
            end
          end
        end
        default: begin
          state_n = FETCH;
          re_n    = 1'b0;
        end
      endcase
    end

    sel_n = re_n ? 4'b1111 : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_VECTOR;
      re_q    <= 1'b0;
      sel_q   <= 4'b0000;
      addr_q  <= RESET_VECTOR;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      re_q    <= re_n;
      sel_q   <= sel_n;
      addr_q  <= addr_n;
      if (redirect_valid) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          q_instr[tail_q] <= imem.instr;
          q_pc[tail_q]    <= addr_q;
          tail_q          <= tail_q + PW'(1);
        end
        if (pop) head_q <= head_q + PW'(1);
        count_q <= count_after;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a latency-programmable cache model, a queue-level reference
// model checked every cycle on the falling edge, and literal expectations per scenario.
module tb_fetch_ctrl;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RV    = 32'h100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fq_valid;
  logic [31:0] fq_instr;
  logic [31:0] fq_pc;
  logic        fq_ready;

  c2c_instr #(.XLEN(XLEN)) bus ();

  fetch_ctrl #(.XLEN(XLEN), .RESET_VECTOR(RV), .FQ_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem           (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fq_valid       (fq_valid),
    .fq_instr       (fq_instr),
    .fq_pc          (fq_pc),
    .fq_ready       (fq_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  // Cache: acks a request after ack_delay cycles of re, for exactly one cycle.
  int ack_delay = 1;
  int wcnt = 0;
  initial begin
    bus.ack   = 1'b0;
    bus.instr = '0;
  end
  always @(posedge clk) begin
    #1;
    if (!reset_n || !bus.re) begin
      bus.ack = 1'b0;
      wcnt    = 0;
    end else begin
      if (bus.ack) wcnt = 0;
      bus.ack = (wcnt >= ack_delay);
      if (bus.ack) bus.instr = instr_of(bus.addr);
      wcnt++;
    end
  end

  // Reference model: queue of fetched PCs, fetch PC, and the request the bus should show.
  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_flush_addr;
  logic        m_flush = 1'b0;
  logic        m_re = 1'b0;
  logic        m_known = 1'b0;

  always @(negedge clk) begin
    if (m_known) begin
      chk("re", bus.re, m_re);
      chk("sel", bus.sel, m_re ? 4'hF : 4'h0);
      chk("addr_align", bus.addr[1:0], 2'b00);
      if (m_re) chk("addr", bus.addr, m_flush ? m_flush_addr : m_pc);
      chk("fq_valid", fq_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("fq_pc", fq_pc, m_q[0]);
        chk("fq_instr", fq_instr, instr_of(m_q[0]));
      end
    end
    if (!reset_n) begin
      m_q.delete();
      m_pc    = RV;
      m_flush = 1'b0;
      m_re    = 1'b0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (redirect_valid) begin
        if (m_re && !bus.ack) begin
          if (!m_flush) m_flush_addr = m_pc;
          m_flush = 1'b1;
        end else begin
          m_flush = 1'b0;
        end
        m_re = 1'b1;
        m_q.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (fq_ready && m_q.size() != 0) void'(m_q.pop_front());
        if (m_re && bus.ack) begin
          if (m_flush) m_flush = 1'b0;
          else begin
            m_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
          end
          m_re = (m_q.size() < DEPTH);
        end else if (!m_re) begin
          m_re = (m_q.size() < DEPTH);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_addr(input string name, input logic [31:0] a, input int limit);
    int cyc = 0;
    while (!(bus.re && bus.addr == a) && cyc < limit) begin
      step();
      cyc++;
    end
    chk(name, (bus.re && bus.addr == a) ? 64'(a) : 64'hDEAD_BEEF, 64'(a));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold;
    int cyc;
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fq_ready       = 1'b1;

    // Reset state
    repeat (3) step();
    chk("rst_re", bus.re, 1'b0);
    chk("rst_sel", bus.sel, 4'h0);
    chk("rst_addr", bus.addr, RV);
    chk("rst_fq_valid", fq_valid, 1'b0);
    chk("rst_fq_pc", fq_pc, 32'h0);
    chk("rst_fq_instr", fq_instr, 32'h0);

    // Sequential fetch from the reset vector
    reset_n = 1'b1;
    wait_addr("first_addr", 32'h100, 3);
    wait_addr("seq_addr_104", 32'h104, 5);
    chk("seq_fq_pc_100", fq_pc, 32'h100);
    chk("seq_fq_instr_100", fq_instr, instr_of(32'h100));
    wait_addr("seq_addr_108", 32'h108, 5);
    chk("seq_fq_pc_104", fq_pc, 32'h104);

    // Queue full: only two entries accepted, then requests stop
    fq_ready = 1'b0;
    do_redirect(32'h0);
    cyc = 0;
    while (bus.re && cyc < 20) begin
      step();
      cyc++;
    end
    repeat (3) step();
    chk("stall_re", bus.re, 1'b0);
    chk("stall_fq_valid", fq_valid, 1'b1);
    chk("stall_head_pc", fq_pc, 32'h0);
    fq_ready = 1'b1;
    step();
    chk("resume_re", bus.re, 1'b1);
    chk("resume_addr", bus.addr, 32'h8);
    chk("resume_head_pc", fq_pc, 32'h4);

    // Redirect while a slow request is outstanding
    fq_ready = 1'b0;
    do_redirect(32'hC);
    wait_addr("pre_flush_C", 32'hC, 5);
    wait_addr("pre_flush_10", 32'h10, 5);
    ack_delay = 3;
    chk("pre_flush_queued", fq_valid, 1'b1);
    do_redirect(32'h2000);
    chk("flush_empty", fq_valid, 1'b0);
    hold = 0;
    while (bus.re && bus.addr == 32'h10 && hold < 20) begin
      hold++;
      step();
    end
    chk("flush_hold_cycles", hold, 3);
    chk("flush_next_addr", bus.addr, 32'h2000);
    chk("flush_no_push", fq_valid, 1'b0);

    // Redirect in the same cycle as an ack
    ack_delay = 1;
    fq_ready  = 1'b1;
    do_redirect(32'h20);
    wait_addr("ackredir_20", 32'h20, 5);
    step();
    do_redirect(32'h3002);
    chk("ackredir_re", bus.re, 1'b1);
    chk("ackredir_addr", bus.addr, 32'h3000);
    chk("ackredir_empty", fq_valid, 1'b0);
    cyc = 0;
    while (!fq_valid && cyc < 10) begin
      step();
      cyc++;
    end
    chk("ackredir_head_pc", fq_pc, 32'h3000);

    // PC wraps past the top of the address space
    do_redirect(32'hFFFF_FFFC);
    wait_addr("wrap_top", 32'hFFFF_FFFC, 5);
    wait_addr("wrap_zero", 32'h0, 5);
    chk("wrap_fq_valid", fq_valid, 1'b1);
    chk("wrap_fq_pc", fq_pc, 32'hFFFF_FFFC);

    // Reset in the middle of a request
    fq_ready = 1'b0;
    do_redirect(32'h3C);
    wait_addr("midrst_40", 32'h40, 5);
    chk("midrst_queued", fq_valid, 1'b1);
    reset_n = 1'b0;
    step();
    chk("midrst_re", bus.re, 1'b0);
    chk("midrst_fq_valid", fq_valid, 1'b0);
    chk("midrst_addr", bus.addr, RV);
    chk("midrst_fq_pc", fq_pc, 32'h0);
    step();
    reset_n  = 1'b1;
    fq_ready = 1'b1;
    wait_addr("restart_100", 32'h100, 3);
    wait_addr("restart_104", 32'h104, 5);
    chk("restart_fq_pc", fq_pc, 32'h100);

    repeat (4) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch controller for the core's front end. Owns the fetch PC and drives the master side of the c2c_instr core-to-cache interface. Buffers returned instructions in a small FIFO for decode and handles redirects (branch/jump/trap) from execute, including redirects that arrive while a cache request is outstanding.

Parameters:
RESET_VECTOR, 'h0 (XLEN bits), address of the first fetch after reset.
FQ_DEPTH, 2, fetch-queue entries; must be a power of two and at least 2.

Ports:
clk  input  1  core clock; all state changes on rising edge.
reset_n  input  1  synchronous, active-low reset.
imem  c2c_instr.master  -  instruction port to cache (re, sel, addr out; ack, instr in).
redirect_valid  input  1  one-cycle pulse; replace the fetch PC and flush.
redirect_pc  input  XLEN  new fetch address; bits [1:0] ignored and treated as 0.
fq_valid  output  1  head of the fetch queue holds a valid instruction.
fq_instr  output  32  instruction at the queue head.
fq_pc  output  XLEN  address of fq_instr.
fq_ready  input  1  decode accepts the head entry; pop when fq_valid && fq_ready.

Behaviour:
- Reset (reset_n=0 at a clock edge): re=0, sel=0, addr=RESET_VECTOR, pc=RESET_VECTOR, queue empty (fq_valid=0, fq_instr=0, fq_pc=0), state=FETCH, discard=0. Any outstanding request is abandoned; the cache shares the reset.
- Bus handshake: re, sel, addr are registered. While re=1 and ack=0, re, sel and addr hold stable. ack is sampled on the clock edge and is valid for exactly one cycle, with instr valid in that cycle. sel=4'b1111 whenever re=1, otherwise 4'b0000.
- Only one request is outstanding at any time.
- Credit: a new request is issued (re=1 next cycle) only if the queue count after this cycle's pop/push is below FQ_DEPTH. An accepted instruction therefore always has a free slot.
- States:
  - FETCH: re=1 with addr=pc. On ack: push {instr, addr}, pc <= pc+4 (wraps modulo 2^XLEN). Next cycle re=1 at the new pc if credit is available, else go to STALL with re=0.
  - STALL: re=0. Return to FETCH (re=1, addr=pc) in the cycle after credit becomes available.
  - FLUSH: entered on a redirect while re=1 and ack=0. re and addr stay held until ack. The returned instr is discarded (no push). Next cycle go to FETCH with addr=pc, where pc already holds redirect_pc.
- Redirect (highest priority):
  - Queue is emptied at the edge; fq_valid=0 in the next cycle. A pop in the same cycle is irrelevant.
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - If re=1 and ack=1 in the same cycle: drop the acked instr and issue redirect_pc in the next cycle (re=1).
  - If re=1 and ack=0: go to FLUSH.
  - If re=0 (STALL): go to FETCH and issue redirect_pc in the next cycle.
  - A redirect received during FLUSH updates the target pc; the state remains FLUSH.
- Queue: circular FIFO with head/tail pointers that wrap at FQ_DEPTH and a count of width clog2(FQ_DEPTH)+1. A simultaneous push and pop leaves count unchanged. fq_instr and fq_pc reflect the head entry combinationally from queue storage.
- Latency: ack at edge N puts the instruction on fq_valid in cycle N+1. With a single-cycle-ack cache and decode always ready, throughput is 1 instruction every 2 cycles (registered re).
- Invariants: count never exceeds FQ_DEPTH; no push when full; no pop when empty; addr[1:0]=0 at all times.

Test Plan:
- Reset release, RESET_VECTOR='h100, cache acks 1 cycle after re, fq_ready=1 -> addr sequence 'h100, 'h104, 'h108; fq_pc matches each; re=0 during reset.
- Hold fq_ready=0, FQ_DEPTH=2 -> exactly 2 entries accepted (pc 'h0, 'h4); re drops to 0 and no third request issues. Raise fq_ready -> re=1 at addr 'h8 in the cycle after the first pop.
- Redirect to 'h2000 while re=1 at 'h10 and ack is delayed 3 cycles -> re/addr='h10 held until ack; that instr is not pushed; next request addr='h2000; queue empty in the cycle after the redirect.
- Redirect to 'h3002 in the same cycle as ack for 'h20 -> 'h20 instr dropped; next addr='h3000.
- pc='hFFFF_FFFC (XLEN=32), ack -> next addr='h0 (wrap).
- reset_n asserted mid-request, re=1 at 'h40 -> re=0 and queue empty after the edge; on release, fetch restarts at RESET_VECTOR.
